// File: rtl/boot_mem_sequencer.sv
// rtl/boot_mem_sequencer.sv - boot-time clear/load sequencer in front of the core memories
// Holds the core in reset, zeroes data memory, copies the boot ROM into instruction memory, then hands over.
module boot_mem_sequencer #(
  parameter int DMEM_WORDS = 256,
  parameter int IMEM_WORDS = 64,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  localparam int ROM_AW    = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1,
  localparam int CNT_MAX   = (DMEM_WORDS > IMEM_WORDS + 1) ? DMEM_WORDS : IMEM_WORDS + 1,
  localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reload,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_rdata,
  input  logic [ADDR_W-1:0] cpu_pc,
  input  logic              cpu_dmem_we,
  input  logic [ADDR_W-1:0] cpu_dmem_addr,
  input  logic [DATA_W-1:0] cpu_dmem_wdata,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, CLEAR, LOAD, RUN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    first_d = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
      CLEAR: begin
        if (cnt_q == CNT_W'(DMEM_WORDS - 1)) begin
          state_d = LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOAD: begin
        // One extra cycle past the last ROM index drains the final ROM read into imem.
        if (cnt_q == CNT_W'(IMEM_WORDS)) begin
          state_d = RUN;
          cnt_d   = '0;
          first_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (reload) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    rom_addr   = '0;
    imem_we    = 1'b0;
    imem_addr  = '0;
    imem_wdata = '0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    cpu_rst    = 1'b1;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_q)
      CLEAR: begin
        dmem_we   = 1'b1;
        dmem_addr = ADDR_W'(cnt_q) << 2;
      end
      LOAD: begin
        if (cnt_q < CNT_W'(IMEM_WORDS)) begin
          rom_addr = ROM_AW'(cnt_q);
        end
        imem_we    = (cnt_q != '0);
        imem_addr  = (ADDR_W'(cnt_q) - ADDR_W'(1)) << 2;
        imem_wdata = rom_rdata;
      end
      RUN: begin
        cpu_rst    = 1'b0;
        busy       = 1'b0;
        done       = first_q;
        imem_addr  = cpu_pc;
        dmem_we    = cpu_dmem_we;
        dmem_addr  = cpu_dmem_addr;
        dmem_wdata = cpu_dmem_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_boot_mem_sequencer.sv
// tb/tb_boot_mem_sequencer.sv - scoreboard bench for boot_mem_sequencer
// Driver queues expected memory writes and done pulses by cycle; a negedge monitor pops and compares.
module tb_boot_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        reload;
  logic [5:0]  rom_addr;
  logic [31:0] rom_rdata = '0;
  logic [9:0]  cpu_pc;
  logic        cpu_dmem_we;
  logic [9:0]  cpu_dmem_addr;
  logic [31:0] cpu_dmem_wdata;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        dmem_we;
  logic [9:0]  dmem_addr;
  logic [31:0] dmem_wdata;
  logic        cpu_rst;
  logic        busy;
  logic        done;

  boot_mem_sequencer dut (
    .clk(clk), .rst(rst), .reload(reload),
    .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .cpu_pc(cpu_pc), .cpu_dmem_we(cpu_dmem_we),
    .cpu_dmem_addr(cpu_dmem_addr), .cpu_dmem_wdata(cpu_dmem_wdata),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Boot ROM: word index tagged with 0xA5 in the top byte, one cycle read latency.
  always @(posedge clk) rom_rdata <= 32'hA500_0000 + 32'(rom_addr);

  typedef struct {
    int          cyc;
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t dq[$];
  wr_t iq[$];
  int  done_q[$];

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_wr(input bit to_imem, input int c, input logic [9:0] a, input logic [31:0] d);
    wr_t w;
    w.cyc  = c;
    w.addr = a;
    w.data = d;
    if (to_imem) iq.push_back(w);
    else         dq.push_back(w);
  endtask

  // base = cycle in which the sequencer leaves IDLE/RUN; its first CLEAR cycle is base+1.
  task automatic push_boot(input int base, input int nclear, input bit full);
    for (int i = 0; i < nclear; i++) push_wr(1'b0, base + 1 + i, 10'(i * 4), 32'h0);
    if (full) begin
      for (int k = 0; k < 64; k++) push_wr(1'b1, base + 258 + k, 10'(k * 4), 32'hA500_0000 + 32'(k));
      done_q.push_back(base + 322);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    wr_t w;
    int  dc;
    if (dmem_we) begin
      if (dq.size() == 0) begin
        chk("dmem_unexpected_addr", {54'd0, dmem_addr}, 64'hFFFF);
      end else begin
        w = dq.pop_front();
        chk("dmem_cycle", 64'(cyc), 64'(w.cyc));
        chk("dmem_addr", 64'(dmem_addr), 64'(w.addr));
        chk("dmem_wdata", 64'(dmem_wdata), 64'(w.data));
      end
    end
    if (imem_we) begin
      if (iq.size() == 0) begin
        chk("imem_unexpected_addr", {54'd0, imem_addr}, 64'hFFFF);
      end else begin
        w = iq.pop_front();
        chk("imem_cycle", 64'(cyc), 64'(w.cyc));
        chk("imem_addr", 64'(imem_addr), 64'(w.addr));
        chk("imem_wdata", 64'(imem_wdata), 64'(w.data));
        chk("cpu_rst_during_load", 64'(cpu_rst), 64'd1);
      end
    end
    if (done) begin
      if (done_q.size() == 0) begin
        chk("done_unexpected_cycle", 64'(cyc), 64'hFFFF_FFFF);
      end else begin
        dc = done_q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(dc));
        chk("cpu_rst_at_done", 64'(cpu_rst), 64'd0);
        chk("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  int b;

  initial begin
    rst            = 1'b1;
    reload         = 1'b0;
    cpu_pc         = '0;
    cpu_dmem_we    = 1'b0;
    cpu_dmem_addr  = '0;
    cpu_dmem_wdata = '0;
    repeat (3) step();
    chk("rst_imem_we", 64'(imem_we), 64'd0);
    chk("rst_dmem_we", 64'(dmem_we), 64'd0);
    chk("rst_imem_addr", 64'(imem_addr), 64'd0);
    chk("rst_dmem_addr", 64'(dmem_addr), 64'd0);
    chk("rst_imem_wdata", 64'(imem_wdata), 64'd0);
    chk("rst_dmem_wdata", 64'(dmem_wdata), 64'd0);
    chk("rst_rom_addr", 64'(rom_addr), 64'd0);
    chk("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_done", 64'(done), 64'd0);

    // Boot 1 from reset release.
    rst = 1'b0;
    b = cyc;
    push_boot(b, 256, 1'b1);
    repeat (322) step();

    // First RUN cycle: pass-through.
    cpu_pc         = 10'h040;
    cpu_dmem_we    = 1'b1;
    cpu_dmem_addr  = 10'h010;
    cpu_dmem_wdata = 32'hDEAD_BEEF;
    push_wr(1'b0, cyc, 10'h010, 32'hDEAD_BEEF);
    #1;
    chk("run_imem_addr", 64'(imem_addr), 64'h40);
    chk("run_imem_we", 64'(imem_we), 64'd0);
    chk("run_cpu_rst", 64'(cpu_rst), 64'd0);

    // Core write in the reload cycle still passes through.
    step();
    cpu_dmem_addr  = 10'h020;
    cpu_dmem_wdata = 32'h1234_5678;
    push_wr(1'b0, cyc, 10'h020, 32'h1234_5678);
    reload = 1'b1;
    b = cyc;
    push_boot(b, 256, 1'b1);
    step();
    reload      = 1'b0;
    cpu_dmem_we = 1'b0;
    chk("reload_busy", 64'(busy), 64'd1);
    chk("reload_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("reload_dmem_we", 64'(dmem_we), 64'd1);
    chk("reload_dmem_addr", 64'(dmem_addr), 64'd0);
    repeat (321) step();

    // Third boot abandoned by reset at CLEAR cnt=100.
    chk("boot2_busy", 64'(busy), 64'd0);
    reload = 1'b1;
    b = cyc;
    push_boot(b, 100, 1'b0);
    step();
    reload = 1'b0;
    repeat (100) step();
    rst = 1'b1;
    #1;
    chk("midrst_dmem_we", 64'(dmem_we), 64'd0);
    chk("midrst_dmem_addr", 64'(dmem_addr), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd1);
    chk("midrst_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("midrst_done", 64'(done), 64'd0);
    repeat (2) step();

    // Restart with reload held: ignored until RUN, then an immediate rerun.
    rst    = 1'b0;
    reload = 1'b1;
    b = cyc;
    push_boot(b, 256, 1'b1);
    repeat (322) step();
    b = cyc;
    push_boot(b, 256, 1'b1);
    repeat (10) step();
    reload = 1'b0;
    repeat (312) step();
    repeat (3) step();
    chk("final_busy", 64'(busy), 64'd0);
    chk("final_cpu_rst", 64'(cpu_rst), 64'd0);

    chk("dmem_queue_left", 64'(dq.size()), 64'd0);
    chk("imem_queue_left", 64'(iq.size()), 64'd0);
    chk("done_queue_left", 64'(done_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
